traffic_light_controller: RTL and testbench
===========================================

// Module: traffic_light_controller
// PURPOSE
// - Two-road intersection controller (North-South, East-West) with a pedestrian indication.
// - Moore FSM cycles through green, yellow and all-red phases on each road.
// - Each road's vehicle sensor extends its own green phase, up to a hard maximum.
// - Top-level leaf block: sensors come in from the board, lamp codes go out to the lamp drivers.
// PARAMETERS
// - GREEN_TIME    default 20  minimum green length, in clk cycles (>=1)
// - MAX_GREEN     default 40  absolute green limit with extension, in cycles (>=GREEN_TIME)
// - YELLOW_TIME   default 5   yellow length, in cycles (>=1)
// - ALL_RED_TIME  default 2   all-red clearance length, in cycles (>=1)
// PORTS
// - clk                in   1  system clock; all logic on rising edge
// - reset              in   1  synchronous, active-high reset
// - sensor_ns          in   1  1 = NS traffic waiting/heavy (level, sampled each edge)
// - sensor_ew          in   1  1 = EW traffic waiting/heavy
// - light_ns           out  2  NS lamp: 00 RED, 01 GREEN, 10 YELLOW (11 never driven)
// - light_ew           out  2  EW lamp, same encoding
// - pedestrian_signal  out  2  00 DONT_WALK, 01 WALK alongside NS, 10 WALK alongside EW, 11 FLASH (macro only)
// BEHAVIOUR
// - Interface: one clock (clk); reset is synchronous and active-high.
// - States, in this order:
//   NS_GREEN -> NS_YELLOW -> RED_1 -> EW_GREEN -> EW_YELLOW -> RED_2 -> NS_GREEN.
// - cnt register, width $clog2(MAX_GREEN+1):
//   - cleared to 0 on every state change;
//   - otherwise increments by 1 per cycle and never wraps.
// - Green exit (X = NS or EW): leave X_GREEN on the edge where either
//   - cnt >= GREEN_TIME-1 and sensor_X == 0, or
//   - cnt == MAX_GREEN-1.
// - Green extension:
//   - sensor_X == 1 at the GREEN_TIME boundary keeps X green;
//   - X leaves green on the first edge the sensor is sampled 0, or at MAX_GREEN cycles.
// - The opposing sensor is ignored. No early termination, no skipping of phases.
// - Yellow lasts exactly YELLOW_TIME cycles.
// - RED_1 and RED_2 each last exactly ALL_RED_TIME cycles.
// - Outputs are decoded from the state register only (Moore), so they change on the same edge as the state:
//   - NS_GREEN: ns=01, ew=00, ped=01
//   - NS_YELLOW: ns=10, ew=00, ped=00
//   - RED_1 and RED_2: ns=00, ew=00, ped=00
//   - EW_GREEN: ns=00, ew=01, ped=10
//   - EW_YELLOW: ns=00, ew=10, ped=00
// - Reset values: state NS_GREEN, cnt 0, light_ns=01, light_ew=00, pedestrian_signal=01.
// - Reset mid-operation: the edge with reset=1 forces the reset values; reset has priority over all transitions.
// - Safety invariant: light_ns and light_ew are never both non-00.
// - Undefined state encodings recover to NS_GREEN with cnt 0 on the next edge.
// - Nominal period with defaults and no sensors: 20+5+2+20+5+2 = 54 cycles.
// CONFIGURATION
// - TLC_PED_CLEARANCE_EN defined:
//   - pedestrian_signal = 11 (flashing don't-walk) during NS_YELLOW and EW_YELLOW.
// - TLC_PED_CLEARANCE_EN undefined:
//   - pedestrian_signal = 00 during both yellow states;
//   - code 11 is never driven.
// - Lamp timing is identical either way.
// TESTING
// - Reset, sensors 0:
//   - first post-reset cycle: ns=01, ew=00, ped=01;
//   - ns=10 at cycle 20; all-red at cycle 25; ew=01, ped=10 at cycle 27.
// - Free run, sensors 0: returns to NS_GREEN at cycle 54, and the cycle repeats exactly.
// - sensor_ns held 1: NS green lasts 40 cycles (MAX_GREEN), then yellow for 5 cycles.
// - sensor_ns=1, deasserted when cnt=29: NS_YELLOW is entered on the following edge (green = 30 cycles).
// - sensor_ew=1 during NS_GREEN: NS green is still 20 cycles, and EW green is extended symmetrically.
// - reset=1 for one edge during EW_YELLOW: next outputs ns=01, ew=00, ped=01; the safety invariant is checked every cycle.

Source files
------------

// File: rtl/traffic_light_controller.sv
// -----------------------------------------------------------------------------
// traffic_light_controller
//
// Two-road (North-South / East-West) intersection controller with a
// pedestrian indication. A Moore FSM steps through
//     NS_GREEN -> NS_YELLOW -> RED_1 -> EW_GREEN -> EW_YELLOW -> RED_2
// and back to NS_GREEN. Each road's vehicle sensor can stretch its own green
// phase beyond GREEN_TIME, but never beyond MAX_GREEN cycles.
//
// Optional feature macro: TLC_PED_CLEARANCE_EN
//     defined   -> pedestrian_signal = 11 (flashing don't-walk) in both yellows
//     undefined -> pedestrian_signal = 00 in both yellows; 11 is never driven
//     Lamp timing is the same in both builds.
//
// Ports
//     clk               in   1  system clock, rising edge
//     reset             in   1  synchronous, active-high reset
//     sensor_ns         in   1  NS traffic waiting (level)
//     sensor_ew         in   1  EW traffic waiting (level)
//     light_ns          out  2  00 RED, 01 GREEN, 10 YELLOW
//     light_ew          out  2  same encoding as light_ns
//     pedestrian_signal out  2  00 DONT_WALK, 01 WALK with NS, 10 WALK with EW,
//                               11 FLASH (only with TLC_PED_CLEARANCE_EN)
//
// Parameters
//     GREEN_TIME   minimum green length in cycles (>=1)
//     MAX_GREEN    absolute green limit in cycles (>=GREEN_TIME)
//     YELLOW_TIME  yellow length in cycles (>=1)
//     ALL_RED_TIME all-red clearance length in cycles (>=1)
// -----------------------------------------------------------------------------
module traffic_light_controller #(
    parameter int GREEN_TIME   = 20,
    parameter int MAX_GREEN    = 40,
    parameter int YELLOW_TIME  = 5,
    parameter int ALL_RED_TIME = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_ns,
    input  logic       sensor_ew,
    output logic [1:0] light_ns,
    output logic [1:0] light_ew,
    output logic [1:0] pedestrian_signal
);

    // Counter must hold the longest phase terminal value. With the default
    // parameters this is $clog2(MAX_GREEN+1); the max() only matters if a
    // yellow or all-red phase were configured longer than MAX_GREEN.
    localparam int LONGEST = (MAX_GREEN > YELLOW_TIME)
                           ? ((MAX_GREEN > ALL_RED_TIME) ? MAX_GREEN : ALL_RED_TIME)
                           : ((YELLOW_TIME > ALL_RED_TIME) ? YELLOW_TIME : ALL_RED_TIME);
    localparam int CNT_W = $clog2(LONGEST + 1);

    // Terminal counts: a phase of N cycles ends on the edge where cnt == N-1.
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

    // Lamp codes
    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;

    // Pedestrian codes
    localparam logic [1:0] PED_DONT_WALK = 2'b00;
    localparam logic [1:0] PED_WALK_NS   = 2'b01;
    localparam logic [1:0] PED_WALK_EW   = 2'b10;
`ifdef TLC_PED_CLEARANCE_EN
    localparam logic [1:0] PED_YELLOW    = 2'b11;
`else
    localparam logic [1:0] PED_YELLOW    = 2'b00;
`endif

    // Encodings 6 and 7 are unused; the FSM recovers from them to NS_GREEN.
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_1     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_2     = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [1:0]       light_ns_r;
    logic [1:0]       light_ew_r;
    logic [1:0]       ped_r;

    // NS lamp decode: green and yellow only in the NS phases, red otherwise.
    function automatic logic [1:0] ns_lamp(input state_t s);
        logic [1:0] code;
        case (s)
            NS_GREEN:  code = LAMP_GREEN;
            NS_YELLOW: code = LAMP_YELLOW;
            default:   code = LAMP_RED;
        endcase
        return code;
    endfunction

    // EW lamp decode: green and yellow only in the EW phases, red otherwise.
    function automatic logic [1:0] ew_lamp(input state_t s);
        logic [1:0] code;
        case (s)
            EW_GREEN:  code = LAMP_GREEN;
            EW_YELLOW: code = LAMP_YELLOW;
            default:   code = LAMP_RED;
        endcase
        return code;
    endfunction

    // Pedestrian decode: walk only alongside a green road.
    function automatic logic [1:0] ped_code(input state_t s);
        logic [1:0] code;
        case (s)
            NS_GREEN:  code = PED_WALK_NS;
            EW_GREEN:  code = PED_WALK_EW;
            NS_YELLOW: code = PED_YELLOW;
            EW_YELLOW: code = PED_YELLOW;
            default:   code = PED_DONT_WALK;
        endcase
        return code;
    endfunction

    // Next-state logic: phase sequencing with sensor-driven green extension.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            NS_GREEN: begin
                // Leave once the minimum has elapsed and nobody waits,
                // or unconditionally at the hard maximum.
                if (((cnt_r >= GREEN_LAST) && !sensor_ns) || (cnt_r == MAX_LAST)) begin
                    state_next_s = NS_YELLOW;
                end else begin
                    state_next_s = NS_GREEN;
                end
            end
            NS_YELLOW: begin
                if (cnt_r == YELLOW_LAST) begin
                    state_next_s = RED_1;
                end else begin
                    state_next_s = NS_YELLOW;
                end
            end
            RED_1: begin
                if (cnt_r == RED_LAST) begin
                    state_next_s = EW_GREEN;
                end else begin
                    state_next_s = RED_1;
                end
            end
            EW_GREEN: begin
                if (((cnt_r >= GREEN_LAST) && !sensor_ew) || (cnt_r == MAX_LAST)) begin
                    state_next_s = EW_YELLOW;
                end else begin
                    state_next_s = EW_GREEN;
                end
            end
            EW_YELLOW: begin
                if (cnt_r == YELLOW_LAST) begin
                    state_next_s = RED_2;
                end else begin
                    state_next_s = EW_YELLOW;
                end
            end
            RED_2: begin
                if (cnt_r == RED_LAST) begin
                    state_next_s = NS_GREEN;
                end else begin
                    state_next_s = RED_2;
                end
            end
            default: begin
                state_next_s = NS_GREEN;
            end
        endcase
    end

    // Phase counter: restart on any state change (including recovery from an
    // illegal encoding), otherwise count up and hold at all-ones.
    always_comb begin
        cnt_next_s = cnt_r;
        if (state_next_s != state_r) begin
            cnt_next_s = '0;
        end else if (cnt_r == CNT_SAT) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // State, counter and output registers. Outputs are decoded from the next
    // state so they are registered yet change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= NS_GREEN;
            cnt_r      <= '0;
            light_ns_r <= LAMP_GREEN;
            light_ew_r <= LAMP_RED;
            ped_r      <= PED_WALK_NS;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            light_ns_r <= ns_lamp(state_next_s);
            light_ew_r <= ew_lamp(state_next_s);
            ped_r      <= ped_code(state_next_s);
        end
    end

    assign light_ns          = light_ns_r;
    assign light_ew          = light_ew_r;
    assign pedestrian_signal = ped_r;

endmodule

// File: tb/tb_traffic_light_controller.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_controller
//
// Directed bench for traffic_light_controller with default parameters.
// Cycle 0 is the cycle that follows the last reset edge; outputs are sampled
// on the falling edge of each cycle. Expected values are hand-derived from
// the phase lengths 20 / 5 / 2 (green extended up to 40).
// -----------------------------------------------------------------------------
module tb_traffic_light_controller;

`ifdef TLC_PED_CLEARANCE_EN
    localparam logic [1:0] PY = 2'b11;
`else
    localparam logic [1:0] PY = 2'b00;
`endif

    logic       clk;
    logic       reset;
    logic       sensor_ns;
    logic       sensor_ew;
    logic [1:0] light_ns;
    logic [1:0] light_ew;
    logic [1:0] pedestrian_signal;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    bit mon_en    = 1'b0;

    traffic_light_controller dut (
        .clk               (clk),
        .reset             (reset),
        .sensor_ns         (sensor_ns),
        .sensor_ew         (sensor_ew),
        .light_ns          (light_ns),
        .light_ew          (light_ew),
        .pedestrian_signal (pedestrian_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the falling edge of cycle k.
    task automatic goto(input int k);
        while (cyc < k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Compare the three outputs against expected codes.
    task automatic chk(input string tag, input logic [1:0] ns, input logic [1:0] ew,
                       input logic [1:0] ped);
        total_cnt++;
        assert ({light_ns, light_ew, pedestrian_signal} === {ns, ew, ped})
            pass_cnt++;
        else
            $error("FAIL %s cyc=%0d got ns=%b ew=%b ped=%b want ns=%b ew=%b ped=%b",
                   tag, cyc, light_ns, light_ew, pedestrian_signal, ns, ew, ped);
    endtask

    // Apply one reset edge from a falling edge; leaves us at cycle 0.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    // Every-cycle safety monitor: never two non-red lamps, no 11 lamp code.
    always @(negedge clk) begin
        if (mon_en) begin
            total_cnt++;
            assert (!((light_ns != 2'b00) && (light_ew != 2'b00)) &&
                    (light_ns !== 2'b11) && (light_ew !== 2'b11)
`ifndef TLC_PED_CLEARANCE_EN
                    && (pedestrian_signal !== 2'b11)
`endif
                   )
                pass_cnt++;
            else
                $error("FAIL safety t=%0t got ns=%b ew=%b ped=%b want exclusive lamps",
                       $time, light_ns, light_ew, pedestrian_signal);
        end
    end

    initial begin
        reset     = 1'b1;
        sensor_ns = 1'b0;
        sensor_ew = 1'b0;
        @(negedge clk);
        do_reset();
        mon_en = 1'b1;

        // Free run, no sensors: 54-cycle period, checked over two rounds.
        chk("rst_state",   2'b01, 2'b00, 2'b01);
        goto(19);  chk("ns_green_end",  2'b01, 2'b00, 2'b01);
        goto(20);  chk("ns_yellow",     2'b10, 2'b00, PY);
        goto(24);  chk("ns_yellow_end", 2'b10, 2'b00, PY);
        goto(25);  chk("red_1",         2'b00, 2'b00, 2'b00);
        goto(26);  chk("red_1_end",     2'b00, 2'b00, 2'b00);
        goto(27);  chk("ew_green",      2'b00, 2'b01, 2'b10);
        goto(46);  chk("ew_green_end",  2'b00, 2'b01, 2'b10);
        goto(47);  chk("ew_yellow",     2'b00, 2'b10, PY);
        goto(52);  chk("red_2",         2'b00, 2'b00, 2'b00);
        goto(53);  chk("red_2_end",     2'b00, 2'b00, 2'b00);
        goto(54);  chk("wrap_ns_green", 2'b01, 2'b00, 2'b01);
        goto(73);  chk("r2_ns_green",   2'b01, 2'b00, 2'b01);
        goto(74);  chk("r2_ns_yellow",  2'b10, 2'b00, PY);
        goto(81);  chk("r2_ew_green",   2'b00, 2'b01, 2'b10);
        goto(101); chk("r2_ew_yellow",  2'b00, 2'b10, PY);
        goto(108); chk("r3_ns_green",   2'b01, 2'b00, 2'b01);

        // sensor_ns held: green runs the full 40 cycles.
        sensor_ns = 1'b1;
        do_reset();
        goto(20); chk("ext_ns_past_min", 2'b01, 2'b00, 2'b01);
        goto(39); chk("ext_ns_max_end",  2'b01, 2'b00, 2'b01);
        goto(40); chk("ext_ns_yellow",   2'b10, 2'b00, PY);
        goto(44); chk("ext_ns_yel_end",  2'b10, 2'b00, PY);
        goto(45); chk("ext_ns_red",      2'b00, 2'b00, 2'b00);
        sensor_ns = 1'b0;

        // sensor_ns released while cnt=29: yellow on the next edge.
        sensor_ns = 1'b1;
        do_reset();
        goto(29); chk("rel_ns_green29", 2'b01, 2'b00, 2'b01);
        sensor_ns = 1'b0;
        goto(30); chk("rel_ns_yellow",  2'b10, 2'b00, PY);
        goto(35); chk("rel_ns_red",     2'b00, 2'b00, 2'b00);

        // sensor_ew held: NS green unaffected, EW green stretched to 40.
        sensor_ew = 1'b1;
        do_reset();
        goto(19); chk("oppo_ns_green",  2'b01, 2'b00, 2'b01);
        goto(20); chk("oppo_ns_yellow", 2'b10, 2'b00, PY);
        goto(27); chk("ext_ew_green",   2'b00, 2'b01, 2'b10);
        goto(66); chk("ext_ew_max_end", 2'b00, 2'b01, 2'b10);
        goto(67); chk("ext_ew_yellow",  2'b00, 2'b10, PY);
        sensor_ew = 1'b0;

        // sensor_ns raised during EW green is ignored; then reset mid-yellow.
        do_reset();
        goto(27); chk("ign_ew_green", 2'b00, 2'b01, 2'b10);
        sensor_ns = 1'b1;
        goto(46); chk("ign_ew_green_end", 2'b00, 2'b01, 2'b10);
        sensor_ns = 1'b0;
        goto(47); chk("ign_ew_yellow", 2'b00, 2'b10, PY);
        goto(48); chk("pre_rst_ew_yellow", 2'b00, 2'b10, PY);
        do_reset();
        chk("mid_rst_state", 2'b01, 2'b00, 2'b01);
        goto(19); chk("post_rst_green", 2'b01, 2'b00, 2'b01);
        goto(20); chk("post_rst_yellow", 2'b10, 2'b00, PY);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
